// File: rtl/core_mem_stage.sv
// Memory stage: registers EX results and runs loads/stores over a req/gnt/rvalid
// data bus, producing one registered writeback result per accepted instruction.
module core_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic [4:0]      i_rd,
    input  logic            i_reg_write,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_stall,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic            o_wb_reg_write,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_misaligned
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              misaligned_q, misaligned_d;

    logic              is_load, is_store, is_mem;
    logic              funct3_legal, addr_misaligned;
    logic [3:0]        st_be;
    logic [XLEN-1:0]   st_wdata;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_data;

    assign is_load  = (i_opcode == OP_LOAD);
    assign is_store = (i_opcode == OP_STORE);
    assign is_mem   = is_load | is_store;

    always_comb begin
        funct3_legal = 1'b0;
        if (is_load) begin
            funct3_legal = (i_funct3 == 3'd0) || (i_funct3 == 3'd1) || (i_funct3 == 3'd2) ||
                           (i_funct3 == 3'd4) || (i_funct3 == 3'd5);
        end else if (is_store) begin
            funct3_legal = (i_funct3 == 3'd0) || (i_funct3 == 3'd1) || (i_funct3 == 3'd2);
        end
        addr_misaligned = ((i_funct3[1:0] == 2'd1) && i_alu_result[0]) ||
                          ((i_funct3[1:0] == 2'd2) && (i_alu_result[1:0] != 2'b00));
    end

    // Store lane steering: data is replicated across lanes, enables pick the target bytes.
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = '0;
        if (is_store) begin
            case (i_funct3[1:0])
                2'd0: begin
                    st_be    = 4'b0001 << i_alu_result[1:0];
                    st_wdata = {4{i_store_data[7:0]}};
                end
                2'd1: begin
                    st_be    = i_alu_result[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{i_store_data[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = i_store_data;
                end
            endcase
        end
    end

    always_comb begin
        ld_byte = i_dmem_rdata[8*addr_q[1:0] +: 8];
        ld_half = i_dmem_rdata[16*addr_q[1] +: 16];
        case (funct3_q)
            3'd0:    ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'd4:    ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'd5:    ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = i_dmem_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        funct3_d       = funct3_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        we_d           = we_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        wb_valid_d     = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_data_d      = wb_data_q;
        misaligned_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (!is_mem) begin
                        wb_valid_d     = 1'b1;
                        wb_rd_d        = i_rd;
                        wb_reg_write_d = i_reg_write && (i_rd != 5'd0);
                        wb_data_d      = i_alu_result;
                    end else if (!funct3_legal || addr_misaligned) begin
                        // Flagged access completes immediately with no bus traffic.
                        wb_valid_d     = 1'b1;
                        wb_rd_d        = i_rd;
                        wb_reg_write_d = 1'b0;
                        wb_data_d      = i_alu_result;
                        misaligned_d   = funct3_legal;
                    end else begin
                        state_d     = S_REQ;
                        addr_d      = i_alu_result;
                        funct3_d    = i_funct3;
                        rd_d        = i_rd;
                        reg_write_d = i_reg_write && is_load;
                        we_d        = is_store;
                        be_d        = st_be;
                        wdata_d     = st_wdata;
                    end
                end
            end
            S_REQ: begin
                if (i_dmem_gnt) begin
                    if (we_q) begin
                        state_d        = S_IDLE;
                        wb_valid_d     = 1'b1;
                        wb_rd_d        = rd_q;
                        wb_reg_write_d = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (i_dmem_rvalid) begin
                    state_d        = S_IDLE;
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = rd_q;
                    wb_reg_write_d = reg_write_q && (rd_q != 5'd0);
                    wb_data_d      = ld_data;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            funct3_q       <= '0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            we_q           <= 1'b0;
            be_q           <= '0;
            wdata_q        <= '0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            wb_data_q      <= '0;
            misaligned_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            funct3_q       <= funct3_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            we_q           <= we_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_data_q      <= wb_data_d;
            misaligned_q   <= misaligned_d;
        end
    end

    assign o_stall        = (state_q != S_IDLE);
    assign o_dmem_req     = (state_q == S_REQ);
    assign o_dmem_we      = we_q;
    assign o_dmem_addr    = {addr_q[XLEN-1:2], 2'b00};
    assign o_dmem_be      = be_q;
    assign o_dmem_wdata   = wdata_q;
    assign o_wb_valid     = wb_valid_q;
    assign o_wb_rd        = wb_rd_q;
    assign o_wb_reg_write = wb_reg_write_q;
    assign o_wb_data      = wb_data_q;
    assign o_misaligned   = misaligned_q;

endmodule

// File: tb/tb_core_mem_stage.sv
// Directed bench for core_mem_stage: inputs change and outputs are sampled 1ns after
// each rising edge; expected values are hand-computed.
module tb_core_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [6:0]  i_opcode;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd;
    logic        i_reg_write;
    logic [31:0] i_alu_result;
    logic [31:0] i_store_data;
    logic        o_stall;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic        o_wb_reg_write;
    logic [31:0] o_wb_data;
    logic        o_misaligned;

    int checks_cnt = 0;
    int errors_cnt = 0;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    core_mem_stage #(.XLEN(32)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .i_opcode       (i_opcode),
        .i_funct3       (i_funct3),
        .i_rd           (i_rd),
        .i_reg_write    (i_reg_write),
        .i_alu_result   (i_alu_result),
        .i_store_data   (i_store_data),
        .o_stall        (o_stall),
        .o_dmem_req     (o_dmem_req),
        .o_dmem_we      (o_dmem_we),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_be      (o_dmem_be),
        .o_dmem_wdata   (o_dmem_wdata),
        .i_dmem_gnt     (i_dmem_gnt),
        .i_dmem_rvalid  (i_dmem_rvalid),
        .i_dmem_rdata   (i_dmem_rdata),
        .o_wb_valid     (o_wb_valid),
        .o_wb_rd        (o_wb_rd),
        .o_wb_reg_write (o_wb_reg_write),
        .o_wb_data      (o_wb_data),
        .o_misaligned   (o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic rw, input logic [31:0] addr, input logic [31:0] sd);
        i_valid      = 1'b1;
        i_opcode     = op;
        i_funct3     = f3;
        i_rd         = rd;
        i_reg_write  = rw;
        i_alu_result = addr;
        i_store_data = sd;
        tick();
        i_valid = 1'b0;
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_valid       = 1'b0;
        i_opcode      = '0;
        i_funct3      = '0;
        i_rd          = '0;
        i_reg_write   = 1'b0;
        i_alu_result  = '0;
        i_store_data  = '0;
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = '0;
        #12;
        check("rst_stall", o_stall, 0);
        check("rst_req", o_dmem_req, 0);
        check("rst_wb_valid", o_wb_valid, 0);
        check("rst_wb_data", o_wb_data, 0);
        check("rst_misaligned", o_misaligned, 0);
        tick();
        i_rst_n = 1'b1;
        tick();

        // ALU op
        i_valid = 1'b1; i_opcode = OP_ALU; i_funct3 = 3'd0; i_rd = 5'd5;
        i_reg_write = 1'b1; i_alu_result = 32'h0000_1234;
        check("alu_stall_pre", o_stall, 0);
        tick();
        i_valid = 1'b0;
        check("alu_wb_valid", o_wb_valid, 1);
        check("alu_wb_data", o_wb_data, 32'h0000_1234);
        check("alu_wb_rd", o_wb_rd, 5);
        check("alu_wb_rw", o_wb_reg_write, 1);
        check("alu_stall", o_stall, 0);
        tick();
        check("alu_wb_pulse", o_wb_valid, 0);

        // LB from lane 3, gnt in the REQ cycle, rvalid two cycles later
        issue(OP_LOAD, 3'd0, 5'd7, 1'b1, 32'h0000_1003, 32'h0);
        check("lb_stall", o_stall, 1);
        check("lb_req", o_dmem_req, 1);
        check("lb_addr", o_dmem_addr, 32'h0000_1000);
        check("lb_we", o_dmem_we, 0);
        check("lb_be", o_dmem_be, 0);
        i_dmem_gnt = 1'b1;
        tick();
        i_dmem_gnt = 1'b0;
        check("lb_wait_req", o_dmem_req, 0);
        check("lb_wait_stall", o_stall, 1);
        tick();
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h80FF_0000;
        check("lb_wait_stall2", o_stall, 1);
        check("lb_no_wb_yet", o_wb_valid, 0);
        tick();
        i_dmem_rvalid = 1'b0;
        check("lb_wb_valid", o_wb_valid, 1);
        check("lb_wb_data", o_wb_data, 32'hFFFF_FF80);
        check("lb_wb_rd", o_wb_rd, 7);
        check("lb_wb_rw", o_wb_reg_write, 1);
        check("lb_stall_end", o_stall, 0);

        // SH upper half, gnt delayed three cycles
        issue(OP_STORE, 3'd1, 5'd0, 1'b0, 32'h0000_2002, 32'hABCD_1234);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sh_req_c%0d", k), o_dmem_req, 1);
            check($sformatf("sh_addr_c%0d", k), o_dmem_addr, 32'h0000_2000);
            check($sformatf("sh_be_c%0d", k), {28'h0, o_dmem_be}, 32'hC);
            check($sformatf("sh_wdata_c%0d", k), o_dmem_wdata, 32'h1234_1234);
            check($sformatf("sh_we_c%0d", k), o_dmem_we, 1);
            check($sformatf("sh_nowb_c%0d", k), o_wb_valid, 0);
            if (k == 3) i_dmem_gnt = 1'b1;
            tick();
        end
        i_dmem_gnt = 1'b0;
        check("sh_wb_valid", o_wb_valid, 1);
        check("sh_wb_rw", o_wb_reg_write, 0);
        check("sh_req_done", o_dmem_req, 0);
        check("sh_stall_done", o_stall, 0);

        // SB lane 2
        issue(OP_STORE, 3'd0, 5'd0, 1'b0, 32'h0000_1002, 32'h0000_0055);
        check("sb_be", {28'h0, o_dmem_be}, 32'h4);
        check("sb_wdata", o_dmem_wdata, 32'h5555_5555);
        i_dmem_gnt = 1'b1;
        tick();
        i_dmem_gnt = 1'b0;
        check("sb_wb_valid", o_wb_valid, 1);

        // Misaligned LW
        issue(OP_LOAD, 3'd2, 5'd3, 1'b1, 32'h0000_1001, 32'h0);
        check("mis_wb_valid", o_wb_valid, 1);
        check("mis_flag", o_misaligned, 1);
        check("mis_rw", o_wb_reg_write, 0);
        check("mis_req", o_dmem_req, 0);
        check("mis_stall", o_stall, 0);
        tick();
        check("mis_req_after", o_dmem_req, 0);
        check("mis_wb_pulse", o_wb_valid, 0);

        // Illegal load funct3
        issue(OP_LOAD, 3'd3, 5'd3, 1'b1, 32'h0000_1000, 32'h0);
        check("ill_wb_valid", o_wb_valid, 1);
        check("ill_flag", o_misaligned, 0);
        check("ill_rw", o_wb_reg_write, 0);
        check("ill_req", o_dmem_req, 0);

        // LBU lane 1
        issue(OP_LOAD, 3'd4, 5'd4, 1'b1, 32'h0000_1001, 32'h0);
        i_dmem_gnt = 1'b1;
        check("lbu_req", o_dmem_req, 1);
        tick();
        i_dmem_gnt = 1'b0;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h0000_AB00;
        tick();
        i_dmem_rvalid = 1'b0;
        check("lbu_wb_valid", o_wb_valid, 1);
        check("lbu_wb_data", o_wb_data, 32'h0000_00AB);
        check("lbu_wb_rw", o_wb_reg_write, 1);
        check("lbu_flag", o_misaligned, 0);

        // LW to x0
        issue(OP_LOAD, 3'd2, 5'd0, 1'b1, 32'h0000_3000, 32'h0);
        i_dmem_gnt = 1'b1;
        tick();
        i_dmem_gnt = 1'b0;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hDEAD_BEEF;
        tick();
        i_dmem_rvalid = 1'b0;
        check("lw0_wb_valid", o_wb_valid, 1);
        check("lw0_wb_data", o_wb_data, 32'hDEAD_BEEF);
        check("lw0_wb_rw", o_wb_reg_write, 0);

        // Asynchronous reset while waiting for load data
        issue(OP_LOAD, 3'd2, 5'd9, 1'b1, 32'h0000_4000, 32'h0);
        i_dmem_gnt = 1'b1;
        tick();
        i_dmem_gnt = 1'b0;
        check("ar_in_wait", o_stall, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("ar_req", o_dmem_req, 0);
        check("ar_stall", o_stall, 0);
        check("ar_wb_valid", o_wb_valid, 0);
        check("ar_wb_data", o_wb_data, 0);
        check("ar_addr", o_dmem_addr, 0);
        check("ar_wdata", o_dmem_wdata, 0);
        tick();
        i_rst_n = 1'b1;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1111_2222;
        tick();
        i_dmem_rvalid = 1'b0;
        check("ar_late_rvalid", o_wb_valid, 0);
        check("ar_late_stall", o_stall, 0);
        tick();
        check("ar_late_rvalid2", o_wb_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
